// File: rtl/cpu_multi_cycle.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one shared bus
// with a ready handshake, a per-access timeout, a sticky bus error and a retire counter.
module cpu_multi_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_bus_in,
  input  logic        rdy,
  output logic [31:0] a_bus,
  output logic [31:0] d_bus_out,
  output logic [1:0]  c_bus,
  output logic        bus_err,
  output logic [31:0] instret,
  output logic [31:0] pc_dbg
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Wait-counter value seen in the last allowed cycle of an access.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [31:0] rf [32];
  logic [7:0]  wait_cnt;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] imm;

  logic [31:0] r_result;
  logic        r_valid;
  logic        bus_active;
  logic        access_done;
  logic        access_abort;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = {{16{ir[15]}}, ir[15:0]};

  always_comb begin
    r_result = '0;
    r_valid  = 1'b1;
    case (funct)
      FN_ADD:  r_result = a_reg + b_reg;
      FN_SUB:  r_result = a_reg - b_reg;
      FN_AND:  r_result = a_reg & b_reg;
      FN_OR:   r_result = a_reg | b_reg;
      FN_SLT:  r_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
      default: r_valid  = 1'b0;
    endcase
  end

  // Strobes are gated by rst_n so every bus output is quiet while reset is held.
  always_comb begin
    a_bus     = '0;
    d_bus_out = '0;
    c_bus     = 2'b00;
    if (rst_n) begin
      if (state == S_FETCH) begin
        a_bus = pc;
        c_bus = 2'b01;
      end else if (state == S_MEM) begin
        a_bus = alu_out;
        if (opcode == OP_SW) begin
          c_bus     = 2'b10;
          d_bus_out = b_reg;
        end else begin
          c_bus = 2'b01;
        end
      end
    end
  end

  assign bus_active   = (c_bus != 2'b00);
  assign access_done  = bus_active && rdy;
  assign access_abort = bus_active && !rdy && (wait_cnt == WAIT_LAST);

  assign wb_dest = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data = (opcode == OP_LW) ? mdr : alu_out;
  assign pc_dbg  = pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && wb_dest != 5'd0) begin
      rf[wb_dest] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
      instret  <= '0;
    end else begin
      if (bus_active) begin
        if (rdy) begin
          wait_cnt <= '0;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_cnt <= '0;
          bus_err  <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end

      case (state)
        S_FETCH: begin
          if (access_done || access_abort) begin
            // An aborted fetch loads 0, which decodes as a nop.
            ir    <= access_done ? d_bus_in : 32'd0;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg <= rf[rs];
          b_reg <= rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              if (r_valid) begin
                alu_out <= r_result;
                state   <= S_WB;
              end else begin
                instret <= instret + 32'd1;
                state   <= S_FETCH;
              end
            end
            OP_ADDI: begin
              alu_out <= a_reg + imm;
              state   <= S_WB;
            end
            OP_LW, OP_SW: begin
              alu_out <= a_reg + imm;
              state   <= S_MEM;
            end
            OP_BEQ: begin
              if (a_reg == b_reg) pc <= pc + {imm[29:0], 2'b00};
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
            OP_J: begin
              pc      <= {pc[31:28], ir[25:0], 2'b00};
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
            default: begin
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (access_done || access_abort) begin
            if (opcode == OP_LW) begin
              mdr   <= access_done ? d_bus_in : 32'd0;
              state <= S_WB;
            end else begin
              instret <= instret + 32'd1;
              state   <= S_FETCH;
            end
          end
        end
        S_WB: begin
          instret <= instret + 32'd1;
          state   <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multi_cycle.sv
// Bench for cpu_multi_cycle: a bus responder with programmable stalls, a write
// scoreboard, an ALU vector table and hand-written multi-cycle sequences.
module tb_cpu_multi_cycle;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] d_bus_in;
  logic        rdy;
  logic [31:0] a_bus;
  logic [31:0] d_bus_out;
  logic [1:0]  c_bus;
  logic        bus_err;
  logic [31:0] instret;
  logic [31:0] pc_dbg;

  // Second core booting high in memory; it only ever sees a jump instruction.
  logic [31:0] j_d_bus_in;
  logic        j_rdy;
  logic [31:0] j_a_bus;
  logic [31:0] j_d_bus_out;
  logic [1:0]  j_c_bus;
  logic        j_bus_err;
  logic [31:0] j_instret;
  logic [31:0] j_pc_dbg;

  cpu_multi_cycle #(.RESET_PC(32'h0000_0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .d_bus_in(d_bus_in), .rdy(rdy),
    .a_bus(a_bus), .d_bus_out(d_bus_out), .c_bus(c_bus),
    .bus_err(bus_err), .instret(instret), .pc_dbg(pc_dbg)
  );

  cpu_multi_cycle #(.RESET_PC(32'h1000_0040), .TIMEOUT(TIMEOUT)) dut_j (
    .clk(clk), .rst_n(rst_n), .d_bus_in(j_d_bus_in), .rdy(j_rdy),
    .a_bus(j_a_bus), .d_bus_out(j_d_bus_out), .c_bus(j_c_bus),
    .bus_err(j_bus_err), .instret(j_instret), .pc_dbg(j_pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_seen = 0;
  int last_wr_cyc = 0;

  logic [31:0] mem [logic [31:0]];
  logic [63:0] exp_q [$];

  logic        stall_en;
  logic [31:0] stall_addr;
  int          stall_cycles;
  logic        in_access;
  int          wait_left;
  int          acc_len;
  logic [31:0] acc_addr;
  logic [1:0]  acc_ctl;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  function automatic logic [31:0] rd_mem(logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got addr/data %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Responds to the current cycle's strobe, then advances to the next cycle.
  task automatic step();
    logic [63:0] e;
    rdy      = 1'($urandom_range(0, 1));
    d_bus_in = $urandom;
    if (c_bus != 2'b00) begin
      if (!in_access) begin
        in_access = 1'b1;
        acc_len   = 0;
        acc_addr  = a_bus;
        acc_ctl   = c_bus;
        wait_left = (stall_en && a_bus == stall_addr) ? stall_cycles : 0;
      end else begin
        chk64("strobe_hold", {30'd0, c_bus, a_bus}, {30'd0, acc_ctl, acc_addr});
      end
      acc_len++;
      if (wait_left == 0) begin
        rdy = 1'b1;
        if (c_bus == 2'b01) begin
          d_bus_in = rd_mem(a_bus);
        end else begin
          mem[a_bus]  = d_bus_out;
          wr_seen++;
          last_wr_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: cycle %0d addr %h data %h", cyc, a_bus, d_bus_out);
          end else begin
            e = exp_q.pop_front();
            chk64("bus_write", {a_bus, d_bus_out}, e);
          end
        end
        in_access = 1'b0;
      end else begin
        rdy = 1'b0;
        if (wait_left > 0) wait_left--;
        if (acc_len == TIMEOUT) in_access = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int k);
    while (cyc < k) step();
  endtask

  task automatic wait_write(input int n, input int limit);
    int target;
    target = wr_seen + n;
    while (wr_seen < target && cyc < limit) step();
    checks++;
    if (wr_seen < target) begin
      errors++;
      $display("FAIL write_timeout: got %0d writes expected %0d by cycle %0d", wr_seen, target, limit);
    end
  endtask

  task automatic new_test();
    mem.delete();
    exp_q.delete();
    stall_en     = 1'b0;
    stall_addr   = '0;
    stall_cycles = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    rdy       = 1'b1;
    d_bus_in  = '0;
    in_access = 1'b0;
    wait_left = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_c_bus", {30'd0, c_bus}, 32'd0);
    chk("rst_a_bus", a_bus, 32'd0);
    chk("rst_d_bus_out", d_bus_out, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_pc_dbg", pc_dbg, 32'h0000_0000);
    chk("rst_j_pc_dbg", j_pc_dbg, 32'h1000_0040);
    rst_n = 1'b1;
    #1;
    cyc = 1;
  endtask

  task automatic end_test(input string name);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 18};
    vecs[1] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h22), 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 18};
    vecs[2] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h24), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 18};
    vecs[3] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h25), 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 18};
    vecs[4] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 18};
    vecs[5] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 18};
    vecs[6] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h2A), 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 18};
    vecs[7] = '{enc_i(6'h08, 5'd1, 5'd3, 16'hFFFF), 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 18};
    vecs[8] = '{enc_r(5'd1, 5'd2, 5'd3, 6'h21), 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 17};
    vecs[9] = '{enc_i(6'h0F, 5'd1, 5'd3, 16'h1234), 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 17};

    j_rdy      = 1'b1;
    j_d_bus_in = enc_j(26'h100);

    // Reset, first fetch, and the jump from 0x1000_0040.
    new_test();
    do_reset();
    chk("first_fetch_a_bus", a_bus, 32'h0);
    chk("first_fetch_c_bus", {30'd0, c_bus}, 32'h1);
    chk("j_first_fetch_a_bus", j_a_bus, 32'h1000_0040);
    goto(4);
    chk("j_target_a_bus", j_a_bus, 32'h1000_0400);
    chk("j_instret", j_instret, 32'd1);

    // addi/addi/add/sw program.
    new_test();
    mem[32'h00] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[32'h04] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[32'h08] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    mem[32'h0C] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0010);
    exp_q.push_back({32'h10, 32'd2});
    do_reset();
    goto(16);
    chk("sw_a_bus", a_bus, 32'h10);
    chk("sw_d_bus_out", d_bus_out, 32'd2);
    chk("sw_c_bus", {30'd0, c_bus}, 32'h2);
    step();
    chk("seq_instret", instret, 32'd4);
    end_test("seq");

    // ALU vector table: lw A, lw B, op, sw result.
    for (int i = 0; i < 10; i++) begin
      new_test();
      mem[32'h00]  = enc_i(6'h23, 5'd0, 5'd1, 16'h0100);
      mem[32'h04]  = enc_i(6'h23, 5'd0, 5'd2, 16'h0104);
      mem[32'h08]  = vecs[i].ins;
      mem[32'h0C]  = enc_i(6'h2B, 5'd0, 5'd3, 16'h0108);
      mem[32'h100] = vecs[i].a;
      mem[32'h104] = vecs[i].b;
      exp_q.push_back({32'h108, vecs[i].exp});
      do_reset();
      wait_write(1, 60);
      chk($sformatf("vec%0d_wr_cycle", i), 32'(last_wr_cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("vec%0d_instret", i), instret, 32'd4);
      end_test("vec");
    end

    // lw with three wait cycles.
    new_test();
    mem[32'h00]  = enc_i(6'h23, 5'd0, 5'd5, 16'h0400);
    mem[32'h04]  = enc_i(6'h2B, 5'd0, 5'd5, 16'h0010);
    mem[32'h400] = 32'hDEAD_BEEF;
    stall_en = 1'b1; stall_addr = 32'h400; stall_cycles = 3;
    exp_q.push_back({32'h10, 32'hDEAD_BEEF});
    do_reset();
    goto(7);
    chk("lw_wait_c_bus", {30'd0, c_bus}, 32'h1);
    chk("lw_wait_a_bus", a_bus, 32'h400);
    goto(9);
    chk("lw_wait_instret", instret, 32'd1);
    chk("lw_wait_next_fetch", a_bus, 32'h4);
    wait_write(1, 40);
    chk("lw_wait_wr_cycle", 32'(last_wr_cyc), 32'd12);
    end_test("lw_wait");

    // lw that never completes: timeout, zero written back, execution continues.
    new_test();
    mem[32'h00]  = enc_i(6'h08, 5'd0, 5'd6, 16'h0055);
    mem[32'h04]  = enc_i(6'h23, 5'd0, 5'd6, 16'h0400);
    mem[32'h08]  = enc_i(6'h2B, 5'd0, 5'd6, 16'h0014);
    mem[32'h400] = 32'h0000_1234;
    stall_en = 1'b1; stall_addr = 32'h400; stall_cycles = -1;
    exp_q.push_back({32'h14, 32'h0});
    do_reset();
    goto(23);
    chk("to_last_c_bus", {30'd0, c_bus}, 32'h1);
    chk("to_last_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    chk("to_after_c_bus", {30'd0, c_bus}, 32'h0);
    chk("to_after_bus_err", {31'd0, bus_err}, 32'd1);
    wait_write(1, 60);
    chk("to_wr_cycle", 32'(last_wr_cyc), 32'd28);
    chk("to_instret", instret, 32'd3);
    chk("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
    end_test("timeout");

    // Fetch that never completes: nop executes, pc moves on.
    new_test();
    stall_en = 1'b1; stall_addr = 32'h0; stall_cycles = -1;
    do_reset();
    goto(17);
    chk("fto_bus_err", {31'd0, bus_err}, 32'd1);
    chk("fto_c_bus", {30'd0, c_bus}, 32'h0);
    goto(19);
    chk("fto_next_fetch", a_bus, 32'h4);
    chk("fto_instret", instret, 32'd1);

    // beq taken backwards.
    new_test();
    mem[32'h00] = enc_j(26'h8);
    mem[32'h20] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFE);
    do_reset();
    goto(4);
    chk("beq_t_at", a_bus, 32'h20);
    goto(7);
    chk("beq_t_target", a_bus, 32'h1C);
    chk("beq_t_instret", instret, 32'd2);

    // beq not taken.
    new_test();
    mem[32'h00] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
    mem[32'h04] = enc_j(26'h8);
    mem[32'h20] = enc_i(6'h04, 5'd1, 5'd0, 16'hFFFE);
    do_reset();
    goto(8);
    chk("beq_nt_at", a_bus, 32'h20);
    goto(11);
    chk("beq_nt_next", a_bus, 32'h24);

    // Register $0 ignores writes.
    new_test();
    mem[32'h00] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[32'h04] = enc_r(5'd0, 5'd0, 5'd4, 6'h20);
    mem[32'h08] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0018);
    mem[32'h0C] = enc_i(6'h2B, 5'd0, 5'd0, 16'h001C);
    exp_q.push_back({32'h18, 32'h0});
    exp_q.push_back({32'h1C, 32'h0});
    do_reset();
    wait_write(2, 60);
    end_test("r0");

    // Reset during a lw wait state.
    new_test();
    mem[32'h00] = enc_i(6'h23, 5'd0, 5'd7, 16'h0400);
    stall_en = 1'b1; stall_addr = 32'h400; stall_cycles = -1;
    do_reset();
    goto(6);
    chk("mid_pre_c_bus", {30'd0, c_bus}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_c_bus", {30'd0, c_bus}, 32'h0);
    chk("mid_pc_dbg", pc_dbg, 32'h0);
    chk("mid_instret", instret, 32'd0);
    chk("mid_bus_err", {31'd0, bus_err}, 32'd0);
    stall_en = 1'b0;
    do_reset();
    chk("mid_refetch_a_bus", a_bus, 32'h0);
    chk("mid_refetch_c_bus", {30'd0, c_bus}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
